// File: rtl/boot_rom_ctrl.sv
// Boot ROM access controller: req/gnt/rvalid core port, pipelined ROM port with ROM_LAT read latency.
// Optional one-entry last-word buffer enabled by defining BOOT_ROM_LAST_WORD_BUF_EN.
module boot_rom_ctrl #(
  parameter  int ADDR_WIDTH = 12,
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_WORDS  = 1024,
  parameter  int ROM_LAT    = 1,
  localparam int OFF        = $clog2(DATA_WIDTH / 8),
  localparam int IDX_W      = ADDR_WIDTH - OFF,
  localparam int RA_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  rom_csn_o,
  output logic [RA_W-1:0]       rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_rdata_i
);

  localparam logic [IDX_W:0] NUM_WORDS_EXT = NUM_WORDS[IDX_W:0];

  logic [IDX_W-1:0]      word_idx;
  logic [IDX_W:0]        idx_ext;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  err_req;
  logic                  legal;
  logic                  hit;
  logic                  issue;
  logic [ROM_LAT-1:0]    pipe_valid;
  logic [ROM_LAT-1:0]    pipe_err;
  logic                  resp_valid;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_data;
  logic [DATA_WIDTH-1:0] data_hold;

  assign word_idx     = addr_i[ADDR_WIDTH-1:OFF];
  assign idx_ext      = {1'b0, word_idx};
  assign misaligned   = |addr_i[OFF-1:0];
  assign out_of_range = (idx_ext >= NUM_WORDS_EXT);
  assign err_req      = misaligned | out_of_range;
  assign legal        = req_i & ~err_req;

  // Range check is done on the full index, so truncation below is lossless for legal requests.
  assign issue      = legal & ~hit & ~rst_i;
  assign gnt_o      = req_i;
  assign rom_csn_o  = ~issue;
  assign rom_addr_o = issue ? word_idx[RA_W-1:0] : '0;

  // Per-request valid/error shift register; its last stage lines up with ROM data.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
    end else begin
      pipe_valid[0] <= req_i;
      pipe_err[0]   <= err_req;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
      end
    end
  end

  assign resp_valid = pipe_valid[ROM_LAT-1];
  assign resp_err   = pipe_err[ROM_LAT-1];

`ifdef BOOT_ROM_LAST_WORD_BUF_EN
  logic                  tag_valid;
  logic [RA_W-1:0]       tag;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [ROM_LAT-1:0]    pipe_hit;
  logic                  resp_hit;

  assign hit      = legal & tag_valid & (tag == word_idx[RA_W-1:0]);
  assign resp_hit = pipe_hit[ROM_LAT-1];

  // Tag is claimed at issue; data lands when that miss returns, always before any hit on it responds.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      tag_valid <= 1'b0;
      tag       <= '0;
      buf_data  <= '0;
      pipe_hit  <= '0;
    end else begin
      if (issue) begin
        tag_valid <= 1'b1;
        tag       <= word_idx[RA_W-1:0];
      end
      if (resp_valid && !resp_err && !resp_hit) begin
        buf_data <= rom_rdata_i;
      end
      pipe_hit[0] <= hit;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe_hit[i] <= pipe_hit[i-1];
      end
    end
  end

  // Response data select: error, buffer hit or ROM.
  always_comb begin
    resp_data = rom_rdata_i;
    if (resp_err) begin
      resp_data = '0;
    end else if (resp_hit) begin
      resp_data = buf_data;
    end else begin
      resp_data = rom_rdata_i;
    end
  end
`else
  assign hit = 1'b0;

  // Response data select: error or ROM.
  always_comb begin
    resp_data = rom_rdata_i;
    if (resp_err) begin
      resp_data = '0;
    end else begin
      resp_data = rom_rdata_i;
    end
  end
`endif

  // Keeps the last response visible while no response is valid.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      data_hold <= '0;
    end else if (resp_valid) begin
      data_hold <= resp_data;
    end else begin
      data_hold <= data_hold;
    end
  end

  assign rvalid_o = resp_valid;
  assign err_o    = resp_valid & resp_err;
  assign rdata_o  = resp_valid ? resp_data : data_hold;

endmodule

// File: tb/tb_boot_rom_ctrl.sv
// Directed self-checking bench for boot_rom_ctrl; four instances share the request bus.
module tb_boot_rom_ctrl;

`ifdef BOOT_ROM_LAST_WORD_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req;
  logic [12:0] addr;

  logic        gnt1, rvalid1, err1, csn1;
  logic [31:0] rdata1, rom_rdata1;
  logic [9:0]  rom_addr1;
  logic        gnt2, rvalid2, err2, csn2;
  logic [31:0] rdata2, rom_rdata2;
  logic [9:0]  rom_addr2;
  logic        gnt3, rvalid3, err3, csn3;
  logic [31:0] rdata3, rom_rdata3;
  logic [9:0]  rom_addr3;
  logic        gnt64, rvalid64, err64, csn64;
  logic [63:0] rdata64, rom_rdata64;
  logic [8:0]  rom_addr64;

  int checks;
  int failures;

  boot_rom_ctrl #(.ADDR_WIDTH(13)) d1 (
    .clk(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .gnt_o(gnt1), .rvalid_o(rvalid1),
    .rdata_o(rdata1), .err_o(err1), .rom_csn_o(csn1), .rom_addr_o(rom_addr1), .rom_rdata_i(rom_rdata1)
  );
  boot_rom_ctrl #(.ROM_LAT(2)) d2 (
    .clk(clk), .rst_i(rst), .req_i(req), .addr_i(addr[11:0]), .gnt_o(gnt2), .rvalid_o(rvalid2),
    .rdata_o(rdata2), .err_o(err2), .rom_csn_o(csn2), .rom_addr_o(rom_addr2), .rom_rdata_i(rom_rdata2)
  );
  boot_rom_ctrl #(.NUM_WORDS(600), .ROM_LAT(3)) d3 (
    .clk(clk), .rst_i(rst), .req_i(req), .addr_i(addr[11:0]), .gnt_o(gnt3), .rvalid_o(rvalid3),
    .rdata_o(rdata3), .err_o(err3), .rom_csn_o(csn3), .rom_addr_o(rom_addr3), .rom_rdata_i(rom_rdata3)
  );
  boot_rom_ctrl #(.DATA_WIDTH(64), .NUM_WORDS(512)) d64 (
    .clk(clk), .rst_i(rst), .req_i(req), .addr_i(addr[11:0]), .gnt_o(gnt64), .rvalid_o(rvalid64),
    .rdata_o(rdata64), .err_o(err64), .rom_csn_o(csn64), .rom_addr_o(rom_addr64), .rom_rdata_i(rom_rdata64)
  );

  function automatic logic [31:0] f32(input int w);
    return {16'hB007, w[15:0]};
  endfunction

  function automatic logic [63:0] f64(input int w);
    return {16'hC0DE, w[15:0], 16'h0BAD, w[15:0]};
  endfunction

  // ROM models: address captured on each edge, data after the configured latency.
  logic [9:0] ra1, ra2_0, ra2_1, ra3_0, ra3_1, ra3_2;
  logic [8:0] ra64;
  logic       rc1;
  always @(posedge clk) begin
    ra1   <= rom_addr1;
    rc1   <= csn1;
    ra2_0 <= rom_addr2;
    ra2_1 <= ra2_0;
    ra3_0 <= rom_addr3;
    ra3_1 <= ra3_0;
    ra3_2 <= ra3_1;
    ra64  <= rom_addr64;
  end
  assign rom_rdata1  = rc1 ? 32'hDEADBEEF : f32(int'(ra1));
  assign rom_rdata2  = f32(int'(ra2_1));
  assign rom_rdata3  = f32(int'(ra3_2));
  assign rom_rdata64 = f64(int'(ra64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic r_rst, input logic r_req, input logic [12:0] r_addr);
    @(negedge clk);
    rst  = r_rst;
    req  = r_req;
    addr = r_addr;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 13'h0000);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    req  = 1'b0;
    addr = 13'h0000;
    tick(1'b1, 1'b0, 13'h0000);
    tick(1'b1, 1'b0, 13'h0000);
    check_val("rst_gnt", 64'(gnt1), 64'd0);
    check_val("rst_rvalid", 64'(rvalid1), 64'd0);
    check_val("rst_err", 64'(err1), 64'd0);
    check_val("rst_rdata", 64'(rdata1), 64'd0);
    check_val("rst_csn", 64'(csn1), 64'd1);
    check_val("rst_rom_addr", 64'(rom_addr1), 64'd0);

    // Back-to-back reads, latency 1
    tick(1'b0, 1'b1, 13'h0000);
    check_val("t1_gnt", 64'(gnt1), 64'd1);
    check_val("t1_csn0", 64'(csn1), 64'd0);
    check_val("t1_addr0", 64'(rom_addr1), 64'd0);
    tick(1'b0, 1'b1, 13'h0004);
    check_val("t1_csn1", 64'(csn1), 64'd0);
    check_val("t1_addr1", 64'(rom_addr1), 64'd1);
    check_val("t1_rv0", 64'(rvalid1), 64'd1);
    check_val("t1_data0", 64'(rdata1), 64'(f32(0)));
    check_val("t1_err0", 64'(err1), 64'd0);
    tick(1'b0, 1'b0, 13'h0000);
    check_val("t1_csn_idle", 64'(csn1), 64'd1);
    check_val("t1_rv1", 64'(rvalid1), 64'd1);
    check_val("t1_data1", 64'(rdata1), 64'(f32(1)));
    tick(1'b0, 1'b0, 13'h0000);
    check_val("t1_rv_off", 64'(rvalid1), 64'd0);
    check_val("t1_hold", 64'(rdata1), 64'(f32(1)));
    idle(4);

    // Four consecutive reads, latency 3
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, (i < 4), 13'h0010 + 13'(4 * i));
      check_val("t2_rvalid", 64'(rvalid3), 64'((i >= 3) && (i <= 6)));
      if ((i >= 3) && (i <= 6)) begin
        check_val("t2_data", 64'(rdata3), 64'(f32(i + 1)));
        check_val("t2_err", 64'(err3), 64'd0);
      end
    end

    // Last legal word and first out-of-range word with NUM_WORDS=600
    tick(1'b0, 1'b1, 13'h095C);
    check_val("t2_csn599", 64'(csn3), 64'd0);
    check_val("t2_addr599", 64'(rom_addr3), 64'd599);
    tick(1'b0, 1'b1, 13'h0960);
    check_val("t2_csn600", 64'(csn3), 64'd1);
    idle(2);
    check_val("t2_rv599", 64'(rvalid3), 64'd1);
    check_val("t2_err599", 64'(err3), 64'd0);
    check_val("t2_data599", 64'(rdata3), 64'(f32(599)));
    idle(1);
    check_val("t2_rv600", 64'(rvalid3), 64'd1);
    check_val("t2_err600", 64'(err3), 64'd1);
    check_val("t2_data600", 64'(rdata3), 64'd0);
    idle(4);

    // Out-of-range and misaligned errors, plus last word 1023
    tick(1'b0, 1'b1, 13'h1000);
    check_val("t3_csn_oor", 64'(csn1), 64'd1);
    check_val("t3_addr_oor", 64'(rom_addr1), 64'd0);
    tick(1'b0, 1'b1, 13'h0002);
    check_val("t3_csn_mis", 64'(csn1), 64'd1);
    check_val("t3_rv_oor", 64'(rvalid1), 64'd1);
    check_val("t3_err_oor", 64'(err1), 64'd1);
    check_val("t3_data_oor", 64'(rdata1), 64'd0);
    tick(1'b0, 1'b0, 13'h0000);
    check_val("t3_rv_mis", 64'(rvalid1), 64'd1);
    check_val("t3_err_mis", 64'(err1), 64'd1);
    check_val("t3_data_mis", 64'(rdata1), 64'd0);
    tick(1'b0, 1'b1, 13'h0FFC);
    check_val("t3_rv_off", 64'(rvalid1), 64'd0);
    check_val("t3_err_off", 64'(err1), 64'd0);
    check_val("t3_csn1023", 64'(csn1), 64'd0);
    check_val("t3_addr1023", 64'(rom_addr1), 64'd1023);
    tick(1'b0, 1'b0, 13'h0000);
    check_val("t3_data1023", 64'(rdata1), 64'(f32(1023)));
    check_val("t3_err1023", 64'(err1), 64'd0);
    idle(4);

    // Reset with two requests in flight, latency 2
    tick(1'b0, 1'b1, 13'h0008);
    tick(1'b0, 1'b1, 13'h000C);
    check_val("t4_rv_early", 64'(rvalid2), 64'd0);
    tick(1'b1, 1'b1, 13'h0010);
    check_val("t4_csn_rst", 64'(csn2), 64'd1);
    check_val("t4_addr_rst", 64'(rom_addr2), 64'd0);
    check_val("t4_rv_rst", 64'(rvalid2), 64'd0);
    tick(1'b0, 1'b0, 13'h0000);
    check_val("t4_rv_drop0", 64'(rvalid2), 64'd0);
    tick(1'b0, 1'b0, 13'h0000);
    check_val("t4_rv_drop1", 64'(rvalid2), 64'd0);
    tick(1'b0, 1'b1, 13'h0014);
    check_val("t4_csn_new", 64'(csn2), 64'd0);
    check_val("t4_addr_new", 64'(rom_addr2), 64'd5);
    tick(1'b0, 1'b0, 13'h0000);
    check_val("t4_rv_lat1", 64'(rvalid2), 64'd0);
    tick(1'b0, 1'b0, 13'h0000);
    check_val("t4_rv_new", 64'(rvalid2), 64'd1);
    check_val("t4_data_new", 64'(rdata2), 64'(f32(5)));
    check_val("t4_err_new", 64'(err2), 64'd0);
    idle(4);

    // Repeated word: buffer hit when enabled, plain ROM reads otherwise
    tick(1'b0, 1'b1, 13'h0020);
    check_val("t5_csn_a", 64'(csn1), 64'd0);
    check_val("t5_addr_a", 64'(rom_addr1), 64'd8);
    tick(1'b0, 1'b1, 13'h0020);
    check_val("t5_csn_b", 64'(csn1), 64'(BUF_EN));
    check_val("t5_data_a", 64'(rdata1), 64'(f32(8)));
    tick(1'b0, 1'b1, 13'h0024);
    check_val("t5_csn_c", 64'(csn1), 64'd0);
    check_val("t5_addr_c", 64'(rom_addr1), 64'd9);
    check_val("t5_rv_b", 64'(rvalid1), 64'd1);
    check_val("t5_data_b", 64'(rdata1), 64'(f32(8)));
    tick(1'b0, 1'b1, 13'h0020);
    check_val("t5_csn_d", 64'(csn1), 64'd0);
    check_val("t5_addr_d", 64'(rom_addr1), 64'd8);
    check_val("t5_data_c", 64'(rdata1), 64'(f32(9)));
    tick(1'b0, 1'b0, 13'h0000);
    check_val("t5_rv_d", 64'(rvalid1), 64'd1);
    check_val("t5_data_d", 64'(rdata1), 64'(f32(8)));
    tick(1'b0, 1'b0, 13'h0000);
    check_val("t5_rv_off", 64'(rvalid1), 64'd0);
    idle(4);

    // 64-bit words: 8-byte alignment
    tick(1'b0, 1'b1, 13'h0008);
    check_val("t6_csn", 64'(csn64), 64'd0);
    check_val("t6_addr", 64'(rom_addr64), 64'd1);
    tick(1'b0, 1'b1, 13'h0004);
    check_val("t6_csn_mis", 64'(csn64), 64'd1);
    check_val("t6_rv", 64'(rvalid64), 64'd1);
    check_val("t6_err", 64'(err64), 64'd0);
    check_val("t6_data", rdata64, f64(1));
    tick(1'b0, 1'b0, 13'h0000);
    check_val("t6_rv_mis", 64'(rvalid64), 64'd1);
    check_val("t6_err_mis", 64'(err64), 64'd1);
    check_val("t6_data_mis", rdata64, 64'd0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
